// File: rtl/clock_divider_pkg.sv
// Shared constants for the synchronous binary clock divider.
// Imported by the divider top and its toggle stage.
package clock_divider_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int WIDTH_MAX = 16;

endpackage

// File: rtl/clock_divider_stage.sv
// One divider stage: a toggle flop that flips when every lower bit is set.
// carry tells the next stage that this and all lower bits are set.
module clock_div_stage
  import clock_divider_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic q,
  output logic carry
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= ~q;
    end
  end

  assign carry = en & q;

endmodule

// File: rtl/clock_divider.sv
// Ripple-free binary divider: count[n] runs at clk / 2^(n+1).
// All bits share clk; toggle enables chain through the stage carries.
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] en;
  logic [WIDTH-1:0] carry;
  logic             unused_carry;

  assign en[0]        = 1'b1;
  assign unused_carry = carry[WIDTH-1];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
    if (gi > 0) begin : g_link
      assign en[gi] = carry[gi-1];
    end

    clock_div_stage u_stage (
      .clk   (clk),
      .rst   (rst),
      .en    (en[gi]),
      .q     (count[gi]),
      .carry (carry[gi])
    );
  end

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider: widths 1, 4 and 8 against an edge-count model.
// The model is simply count = edges since release mod 2^WIDTH.
module tb_clock_divider;

  logic       clk;
  logic       rst;
  logic [3:0] c4;
  logic [0:0] c1;
  logic [7:0] c8;

  int pass;
  int total;
  int n;
  int chg;

  clock_divider #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .count (c4)
  );

  clock_divider #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .count (c1)
  );

  clock_divider #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .count (c8)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(c4) chg++;

  task automatic tick();
    @(posedge clk);
    if (rst) n++;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      #9;
      total++;
      if ({c8, c1, c4} !== 13'd0) begin
        $display("FAIL reset_hold t=%0t got c4=%0d c1=%0d c8=%0d want 0",
                 $time, c4, c1, c8);
      end else pass++;
    end
  endtask

  task automatic test_count();
    do_reset();
    release_rst();
    repeat (5) tick();
    total++;
    if (c4 !== 4'd5 || c8 !== 8'd5 || c1 !== 1'b1) begin
      $display("FAIL count5 got c4=%0d c1=%0d c8=%0d want 5/1/5",
               c4, c1, c8);
    end else pass++;
    repeat (11) tick();
    total++;
    if (c4 !== 4'd0 || c8 !== 8'd16 || c1 !== 1'b0) begin
      $display("FAIL count16 got c4=%0d c1=%0d c8=%0d want 0/0/16",
               c4, c1, c8);
    end else pass++;
  endtask

  task automatic test_period();
    time rise [4];
    logic [3:0] prev;
    int edges;
    do_reset();
    release_rst();
    for (int b = 0; b < 4; b++) rise[b] = 0;
    prev = 4'd0;
    edges = 40 + int'($urandom_range(0, 24));
    for (int k = 0; k < edges; k++) begin
      tick();
      total++;
      if (c4 !== 4'(n % 16)) begin
        $display("FAIL period_val edge=%0d got %0d want %0d",
                 n, c4, n % 16);
      end else pass++;
      for (int b = 0; b < 4; b++) begin
        if (!prev[b] && c4[b]) begin
          if (rise[b] != 0) begin
            total++;
            if ($time - rise[b] != time'(20 << (b + 1))) begin
              $display("FAIL period bit%0d got %0t want %0d",
                       b, $time - rise[b], 20 << (b + 1));
            end else pass++;
          end
          rise[b] = $time;
        end else if (prev[b] && !c4[b]) begin
          total++;
          if ($time - rise[b] != time'(10 << (b + 1))) begin
            $display("FAIL high_time bit%0d got %0t want %0d",
                     b, $time - rise[b], 10 << (b + 1));
          end else pass++;
        end
      end
      prev = c4;
    end
  endtask

  task automatic test_async();
    time t0;
    do_reset();
    release_rst();
    repeat (9) tick();
    total++;
    if (c4 !== 4'd9) begin
      $display("FAIL pre_async got %0d want 9", c4);
    end else pass++;
    #4;
    rst = 1'b0;
    n = 0;
    t0 = $time;
    fork
      wait (c4 == 4'd0);
      #1;
    join_any
    disable fork;
    total++;
    if (c4 !== 4'd0 || $time != t0) begin
      $display("FAIL async_clear got %0d at %0t want 0 at %0t",
               c4, $time, t0);
    end else pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (c4 !== 4'd0) begin
        $display("FAIL async_hold edge=%0d got %0d want 0", i, c4);
      end else pass++;
    end
    release_rst();
    tick();
    total++;
    if (c4 !== 4'd1) begin
      $display("FAIL async_release got %0d want 1", c4);
    end else pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    release_rst();
    repeat (15) tick();
    total++;
    if (c4 !== 4'd15) begin
      $display("FAIL pre_wrap got %0d want 15", c4);
    end else pass++;
    chg = 0;
    tick();
    total++;
    if (c4 !== 4'd0 || chg != 1) begin
      $display("FAIL wrap got %0d changes=%0d want 0 changes=1",
               c4, chg);
    end else pass++;
  endtask

  task automatic test_sweep();
    do_reset();
    release_rst();
    repeat (260) begin
      tick();
      total++;
      if (c1 !== 1'(n % 2) || c8 !== 8'(n % 256)) begin
        $display("FAIL sweep edge=%0d got c1=%0d c8=%0d want %0d/%0d",
                 n, c1, c8, n % 2, n % 256);
      end else pass++;
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      #(int'($urandom_range(2, 8)));
      rst = 1'b0;
      n = 0;
      #1;
      total++;
      if ({c8, c1, c4} !== 13'd0) begin
        $display("FAIL rand_rst round=%0d got c4=%0d c8=%0d want 0",
                 r, c4, c8);
      end else pass++;
      repeat (int'($urandom_range(0, 2))) tick();
      release_rst();
      repeat (int'($urandom_range(5, 40))) begin
        tick();
        total++;
        if (c4 !== 4'(n % 16) || c8 !== 8'(n % 256)
            || c1 !== 1'(n % 2)) begin
          $display("FAIL rand_run edge=%0d got %0d/%0d/%0d want %0d",
                   n, c4, c1, c8, n);
        end else pass++;
      end
    end
  endtask

  initial begin
    pass = 0;
    total = 0;
    chg = 0;
    test_reset();
    test_count();
    test_period();
    test_async();
    test_wrap();
    test_sweep();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
